ni_flit_credit_out_buffer: RTL and testbench

- NoC-side output stage that sits directly downstream of the NI response packetizer (axi_ni_resend).
- Accepts flits on a write/full interface and stores them in a DEPTH-entry FIFO.
- Drives them onto the switch link under credit-based flow control: one credit per free downstream input-buffer slot, with credits returned as single-cycle pulses.
- Replaces the stall-based output buffer where switches run credit links.

---
 rtl/ni_flit_credit_out_buffer_pkg.sv | 13 +
 rtl/ni_credit_counter.sv | 30 +++
 rtl/ni_flit_credit_out_buffer.sv | 81 ++++++++
 tb/tb_ni_flit_credit_out_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ni_flit_credit_out_buffer_pkg.sv
// Shared NoC constants for the credit-based NI output stage: flit width,
// credit counter sizing and the tail bit position within a stored FIFO entry.
package ni_flit_credit_out_buffer_pkg;
  localparam int FLIT_WIDTH_DEF  = 80;
  localparam int CREDITS_DEF     = 6;
  localparam int LOG_CREDITS_DEF = 4;
  localparam int TAIL_POS_DEF    = FLIT_WIDTH_DEF;

  // A stored entry is {tail, flit}, so the tail sits just above the flit bits.
  function automatic int tail_pos(input int flit_width);
    return flit_width;
  endfunction
endpackage

// File: rtl/ni_credit_counter.sv
// Saturating up/down credit counter: resets to CREDITS, counts down on send,
// up on a returned credit, and flags a return that would exceed CREDITS.
module ni_credit_counter
  import ni_flit_credit_out_buffer_pkg::*;
#(
  parameter int CREDITS     = CREDITS_DEF,
  parameter int LOG_CREDITS = LOG_CREDITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec,
  input  logic                   inc,
  output logic [LOG_CREDITS-1:0] cnt,
  output logic                   credit_err
);
  localparam logic [LOG_CREDITS-1:0] MAX = LOG_CREDITS'(CREDITS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= MAX;
      credit_err <= 1'b0;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end else if (inc && !dec) begin
      // A return with every downstream slot already credited is spurious.
      if (cnt == MAX) credit_err <= 1'b1;
      else            cnt        <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ni_flit_credit_out_buffer.sv
// NI output buffer: queues packetizer flits in a DEPTH-entry FIFO and launches
// them onto a credit-flow-controlled switch link, one flit per available credit.
module ni_flit_credit_out_buffer
  import ni_flit_credit_out_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int DEPTH       = 6,
  parameter int LOG_DEPTH   = 3,
  parameter int CREDITS     = CREDITS_DEF,
  parameter int LOG_CREDITS = LOG_CREDITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic                   tail_in,
  input  logic                   write,
  output logic                   full,
  output logic [FLIT_WIDTH-1:0]  FLIT_out,
  output logic                   VALID_out,
  output logic                   FWDAUX1_out,
  input  logic                   BWDAUX1_in,
  output logic [LOG_CREDITS-1:0] credits_avail,
  output logic                   overflow_err,
  output logic                   credit_err
);
  localparam int TAIL = tail_pos(FLIT_WIDTH);
  localparam logic [LOG_DEPTH-1:0] LAST = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0]   CAP  = (LOG_DEPTH + 1)'(DEPTH);

  logic [FLIT_WIDTH:0]  mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 push, send;

  // full decodes only the count register, so write never reaches it.
  assign full = (count == CAP);
  assign push = write && !full;
  assign send = (count != '0) && (credits_avail != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tail_in, data_in};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      VALID_out    <= 1'b0;
      FLIT_out     <= '0;
      FWDAUX1_out  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (write && full) overflow_err <= 1'b1;
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      VALID_out <= send;
      if (send) begin
        FLIT_out    <= mem[rd_ptr][FLIT_WIDTH-1:0];
        FWDAUX1_out <= mem[rd_ptr][TAIL];
        rd_ptr      <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, send})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  ni_credit_counter #(
    .CREDITS    (CREDITS),
    .LOG_CREDITS(LOG_CREDITS)
  ) u_credits (
    .clk       (clk),
    .rst       (rst),
    .dec       (send),
    .inc       (BWDAUX1_in),
    .cnt       (credits_avail),
    .credit_err(credit_err)
  );
endmodule

// File: tb/tb_ni_flit_credit_out_buffer.sv
// Directed bench for the credit-based NI output buffer (DEPTH=6, CREDITS=6).
module tb_ni_flit_credit_out_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] data_in = '0;
  logic        tail_in = 1'b0;
  logic        write = 1'b0;
  logic        full;
  logic [79:0] FLIT_out;
  logic        VALID_out;
  logic        FWDAUX1_out;
  logic        BWDAUX1_in = 1'b0;
  logic [3:0]  credits_avail;
  logic        overflow_err;
  logic        credit_err;

  int errors = 0;
  int checks = 0;

  ni_flit_credit_out_buffer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tail_in(tail_in), .write(write),
    .full(full), .FLIT_out(FLIT_out), .VALID_out(VALID_out),
    .FWDAUX1_out(FWDAUX1_out), .BWDAUX1_in(BWDAUX1_in),
    .credits_avail(credits_avail), .overflow_err(overflow_err),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk(input int i);
    logic [79:0] v;
    v = {16'hF00D, 48'h0, 16'(i)};
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (VALID_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", VALID_out); end
    checks++; if (FLIT_out !== 80'h0) begin errors++; $display("FAIL reset_flit: got %0h exp 0", FLIT_out); end
    checks++; if (FWDAUX1_out !== 1'b0) begin errors++; $display("FAIL reset_tail: got %0b exp 0", FWDAUX1_out); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b exp 0", full); end
    checks++; if (credits_avail !== 4'd6) begin errors++; $display("FAIL reset_credits: got %0d exp 6", credits_avail); end
    checks++; if ({overflow_err, credit_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %0b exp 00", {overflow_err, credit_err}); end
  endtask

  task automatic test_single();
    data_in = 80'hA5; tail_in = 1'b1; write = 1'b1;
    tick();
    write = 1'b0; tail_in = 1'b0;
    checks++; if (VALID_out !== 1'b0) begin errors++; $display("FAIL single_early: got %0b exp 0", VALID_out); end
    tick();
    checks++; if (VALID_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b exp 1", VALID_out); end
    checks++; if (FLIT_out !== 80'hA5) begin errors++; $display("FAIL single_flit: got %0h exp a5", FLIT_out); end
    checks++; if (FWDAUX1_out !== 1'b1) begin errors++; $display("FAIL single_tail: got %0b exp 1", FWDAUX1_out); end
    checks++; if (credits_avail !== 4'd5) begin errors++; $display("FAIL single_credits: got %0d exp 5", credits_avail); end
    BWDAUX1_in = 1'b1;
    tick();
    BWDAUX1_in = 1'b0;
    checks++; if (VALID_out !== 1'b0 || FLIT_out !== 80'hA5) begin errors++; $display("FAIL single_hold: got v=%0b %0h exp v=0 a5", VALID_out, FLIT_out); end
    checks++; if (credits_avail !== 4'd6) begin errors++; $display("FAIL single_return: got %0d exp 6", credits_avail); end
  endtask

  // 13 writes, no returns: 6 flits leave, 6 fill the FIFO, the 13th overflows.
  task automatic test_exhaust(output int nxt);
    int vcnt = 0;
    nxt = 0;
    for (int i = 0; i < 17; i++) begin
      write = (i < 13); data_in = mk(i); tail_in = i[0];
      tick();
      if (VALID_out) begin
        vcnt++;
        checks++; if (FLIT_out !== mk(nxt) || FWDAUX1_out !== nxt[0]) begin errors++; $display("FAIL exhaust_order: got %0h/%0b exp %0h/%0b", FLIT_out, FWDAUX1_out, mk(nxt), nxt[0]); end
        nxt++;
      end
    end
    write = 1'b0;
    checks++; if (vcnt != 6) begin errors++; $display("FAIL exhaust_sends: got %0d exp 6", vcnt); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL exhaust_full: got %0b exp 1", full); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL exhaust_overflow: got %0b exp 1", overflow_err); end
    checks++; if (credits_avail !== 4'd0) begin errors++; $display("FAIL exhaust_credits: got %0d exp 0", credits_avail); end
  endtask

  task automatic test_credit_release(input int start);
    int nxt = start;
    BWDAUX1_in = 1'b1;
    tick();
    BWDAUX1_in = 1'b0;
    checks++; if (VALID_out !== 1'b0 || credits_avail !== 4'd1) begin errors++; $display("FAIL release_m1: got v=%0b c=%0d exp v=0 c=1", VALID_out, credits_avail); end
    tick();
    checks++; if (VALID_out !== 1'b1 || FLIT_out !== mk(6)) begin errors++; $display("FAIL release_m2: got v=%0b %0h exp v=1 %0h", VALID_out, FLIT_out, mk(6)); end
    checks++; if (credits_avail !== 4'd0) begin errors++; $display("FAIL release_credits: got %0d exp 0", credits_avail); end
    nxt = 7;
    tick();
    checks++; if (VALID_out !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL release_hold: got v=%0b full=%0b exp 0 0", VALID_out, full); end
    // Drain the remaining five with a burst of returns.
    for (int i = 0; i < 8; i++) begin
      BWDAUX1_in = (i < 5);
      tick();
      if (VALID_out) begin
        checks++; if (FLIT_out !== mk(nxt)) begin errors++; $display("FAIL release_order: got %0h exp %0h", FLIT_out, mk(nxt)); end
        nxt++;
      end
    end
    BWDAUX1_in = 1'b0;
    checks++; if (nxt != 12) begin errors++; $display("FAIL release_drained: got %0d exp 12", nxt); end
    BWDAUX1_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    BWDAUX1_in = 1'b0;
    checks++; if (credits_avail !== 4'd6 || credit_err !== 1'b0) begin errors++; $display("FAIL release_refill: got c=%0d err=%0b exp 6 0", credits_avail, credit_err); end
  endtask

  // Credit returned the cycle each flit appears: counter holds at 5, no bubbles.
  task automatic test_back_to_back();
    int nxt = 0;
    for (int i = 0; i < 28; i++) begin
      write = (i < 24); data_in = mk(100 + i); tail_in = i[1];
      BWDAUX1_in = VALID_out;
      tick();
      checks++; if (VALID_out !== (i >= 1 && i <= 24)) begin errors++; $display("FAIL b2b_valid@%0d: got %0b exp %0b", i, VALID_out, (i >= 1 && i <= 24)); end
      if (VALID_out) begin
        checks++; if (FLIT_out !== mk(100 + nxt) || FWDAUX1_out !== nxt[1] || credits_avail !== 4'd5) begin errors++; $display("FAIL b2b_flit: got %0h/%0b c=%0d exp %0h/%0b c=5", FLIT_out, FWDAUX1_out, credits_avail, mk(100 + nxt), nxt[1]); end
        nxt++;
      end
    end
    write = 1'b0; BWDAUX1_in = 1'b0;
    checks++; if (nxt != 24 || credits_avail !== 4'd6) begin errors++; $display("FAIL b2b_end: got n=%0d c=%0d exp 24 6", nxt, credits_avail); end
  endtask

  task automatic test_spurious();
    BWDAUX1_in = 1'b1;
    tick();
    BWDAUX1_in = 1'b0;
    checks++; if (credits_avail !== 4'd6) begin errors++; $display("FAIL spurious_sat: got %0d exp 6", credits_avail); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL spurious_err: got %0b exp 1", credit_err); end
    tick(); tick();
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL spurious_sticky: got %0b exp 1", credit_err); end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; data_in = mk(200 + i); tail_in = 1'b0;
      tick();
    end
    write = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (VALID_out !== 1'b0 || FLIT_out !== 80'h0) begin errors++; $display("FAIL midrst_out: got v=%0b %0h exp 0 0", VALID_out, FLIT_out); end
    checks++; if (full !== 1'b0 || credits_avail !== 4'd6) begin errors++; $display("FAIL midrst_state: got full=%0b c=%0d exp 0 6", full, credits_avail); end
    checks++; if ({overflow_err, credit_err} !== 2'b00) begin errors++; $display("FAIL midrst_errs: got %0b exp 00", {overflow_err, credit_err}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (VALID_out !== 1'b0) begin errors++; $display("FAIL midrst_stale@%0d: got %0b exp 0", i, VALID_out); end
    end
  endtask

  initial begin
    int nxt;
    test_reset();
    test_single();
    test_exhaust(nxt);
    test_credit_release(nxt);
    test_back_to_back();
    test_spurious();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
